fetch_decode_unit: RTL

- Upstream neighbour of the single-cycle datapath (register file, operand mux, ALU); owns the program counter.
- Fetches 32-bit instructions over a variable-latency instruction-memory handshake and decodes them into the datapath's control fields (rs1/rs2/rd, imm_op, alu_src, alu_ctrl, reg_write).
- Resolves BNE using the datapath's equality result to pick the next PC.

---
 rtl/fetch_decode_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_unit
// Description : Program-counter owner and front end of the single-cycle
//               datapath. Fetches one 32-bit instruction at a time over a
//               variable-latency req/ack memory handshake, decodes ADDI, ADD
//               and BNE into datapath control fields and resolves BNE with
//               the datapath equality flag to select the next PC.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               imem_req/addr      - fetch request and address (= pc)
//               imem_ack/rdata     - fetch completion and instruction word
//               stall              - hold the executing instruction
//               eq_in              - datapath equality flag (BNE resolution)
//               pc, instr_valid    - current instruction address / execute
//               rs1, rs2, rd       - register indices (6-bit)
//               reg_write, imm_op, alu_src, alu_ctrl - datapath controls
//               illegal            - one-cycle pulse on retire of a bad
//                                    opcode or misaligned branch target
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        eq_in,
    output logic [31:0] pc,
    output logic        instr_valid,
    output logic [5:0]  rs1,
    output logic [5:0]  rs2,
    output logic [5:0]  rd,
    output logic        reg_write,
    output logic [31:0] imm_op,
    output logic        alu_src,
    output logic        alu_ctrl,
    output logic        illegal
);

    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_imem_req;
    logic        r_instr_valid;

    // ------------------------------------------------------------------
    // Decode of the instruction register
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_is_addi;
    logic        w_is_add;
    logic        w_is_bne;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_b;

    assign w_opcode  = r_instr[6:0];
    assign w_f3      = r_instr[14:12];
    assign w_f7      = r_instr[31:25];
    assign w_is_addi = (w_opcode == c_OP_IMM)    && (w_f3 == 3'b000);
    assign w_is_add  = (w_opcode == c_OP_REG)    && (w_f3 == 3'b000) && (w_f7 == 7'b0000000);
    assign w_is_bne  = (w_opcode == c_OP_BRANCH) && (w_f3 == 3'b001);
    assign w_imm_i   = {{20{r_instr[31]}}, r_instr[31:20]};
    assign w_imm_b   = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                        r_instr[30:25], r_instr[11:8], 1'b0};

    logic [5:0]  w_rs1;
    logic [5:0]  w_rs2;
    logic [5:0]  w_rd;
    logic        w_reg_write;
    logic [31:0] w_imm;
    logic        w_alu_src;
    logic        w_alu_ctrl;
    logic        w_legal;

    always_comb begin
        w_rs1       = 6'd0;
        w_rs2       = 6'd0;
        w_rd        = 6'd0;
        w_reg_write = 1'b0;
        w_imm       = 32'd0;
        w_alu_src   = 1'b0;
        w_alu_ctrl  = 1'b0;
        w_legal     = 1'b1;
        if (w_is_addi) begin
            w_rs1       = {1'b0, r_instr[19:15]};
            w_rd        = {1'b0, r_instr[11:7]};
            w_reg_write = 1'b1;
            w_imm       = w_imm_i;
            w_alu_src   = 1'b1;
        end else if (w_is_add) begin
            w_rs1       = {1'b0, r_instr[19:15]};
            w_rs2       = {1'b0, r_instr[24:20]};
            w_rd        = {1'b0, r_instr[11:7]};
            w_reg_write = 1'b1;
        end else if (w_is_bne) begin
            w_rs1       = {1'b0, r_instr[19:15]};
            w_rs2       = {1'b0, r_instr[24:20]};
            w_imm       = w_imm_b;
            w_alu_ctrl  = 1'b1;
        end else begin
            w_legal     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Next-PC selection; a taken branch to a non-word-aligned target is
    // flagged and replaced by the sequential fall-through address.
    // ------------------------------------------------------------------
    logic [31:0] w_target;
    logic        w_taken;
    logic        w_misaligned;
    logic [31:0] w_pc_next;
    logic        w_retire;

    assign w_target     = r_pc + w_imm_b;
    assign w_taken      = w_is_bne && !eq_in;
    assign w_misaligned = w_taken && w_target[1];
    assign w_pc_next    = (w_taken && !w_target[1]) ? w_target : (r_pc + 32'd4);
    assign w_retire     = (r_state == S_EXEC) && !stall;

    // ------------------------------------------------------------------
    // Control FSM with registered handshake/valid outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_state       <= S_EXEC;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        r_pc          <= w_pc_next;
                        r_state       <= S_FETCH;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs; decoded fields are forced to zero outside EXEC
    // ------------------------------------------------------------------
    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr_valid = r_instr_valid;
    assign rs1         = r_instr_valid ? w_rs1 : 6'd0;
    assign rs2         = r_instr_valid ? w_rs2 : 6'd0;
    assign rd          = r_instr_valid ? w_rd  : 6'd0;
    assign reg_write   = r_instr_valid && w_reg_write;
    assign imm_op      = r_instr_valid ? w_imm : 32'd0;
    assign alu_src     = r_instr_valid && w_alu_src;
    assign alu_ctrl    = r_instr_valid && w_alu_ctrl;
    // Only on the retiring cycle, so a stalled instruction pulses once.
    assign illegal     = w_retire && (!w_legal || w_misaligned);

endmodule
`default_nettype wire
